l15_fwd_responder: RTL

//  Private-cache-side responder for L2 forward requests. Receives 2-flit LOAD_FWD/STORE_FWD/INV_FWD

---
 rtl/l15_fwd_responder.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/l15_fwd_responder.sv
// rtl/l15_fwd_responder.sv - L1.5 responder for L2 LOAD/STORE/INV forward requests with a direct-mapped line table.
// Optional feature macro: L15_FWD_ERRCNT_EN (counts dropped unknown-type requests on err_cnt).
module l15_fwd_responder #(
    parameter int          LINES     = 8,
    parameter logic [7:0]  T_LD_FWD  = 8'd16,
    parameter logic [7:0]  T_ST_FWD  = 8'd17,
    parameter logic [7:0]  T_INV_FWD = 8'd18,
    parameter logic [7:0]  T_LD_ACK  = 8'd21,
    parameter logic [7:0]  T_ST_ACK  = 8'd22,
    parameter logic [7:0]  T_INV_ACK = 8'd23
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] noc2_data_in,
    input  logic        noc2_valid_in,
    output logic        noc2_ready_in,
    output logic [63:0] noc3_data_out,
    output logic        noc3_valid_out,
    input  logic        noc3_ready_out,
    input  logic        fill_valid,
    output logic        fill_ready,
    input  logic [39:0] fill_addr,
    input  logic [63:0] fill_data,
    input  logic        fill_dirty,
    output logic [7:0]  err_cnt
);
    localparam int IDXW = $clog2(LINES);
    localparam int TAGW = 40 - 6 - IDXW;

    typedef enum logic [2:0] {
        S_RX_HDR, S_RX_ADDR, S_LOOKUP, S_TX_HDR, S_TX_ADDR, S_TX_DATA
    } state_t;

    state_t            r_state;
    logic [63:0]       r_hdr;
    logic [39:0]       r_addr;
    logic              r_len2;
    logic [63:0]       r_rdata;
    logic              r_noc3_valid;
    logic [63:0]       r_noc3_data;

    logic [LINES-1:0]  r_vld;
    logic [LINES-1:0]  r_dirty;
    logic [TAGW-1:0]   r_tag  [LINES];
    logic [63:0]       r_data [LINES];

    logic              r_fill_pend;
    logic [IDXW-1:0]   r_fill_idx;
    logic [TAGW-1:0]   r_fill_tag;
    logic [63:0]       r_fill_data;
    logic              r_fill_dirty;

    logic [IDXW-1:0]   w_idx;
    logic [TAGW-1:0]   w_tag;
    logic              w_hit;
    logic              w_dirty;
    logic [7:0]        w_type;
    logic              w_known;
    logic [7:0]        w_ack_type;
    logic              w_len2;
    logic              w_clr_vld;
    logic              w_clr_dirty;
    logic [63:0]       w_resp_hdr;
    logic              w_noc2_fire;
    logic              w_noc3_fire;
    logic              w_fill_fire;

    assign noc2_ready_in  = (r_state == S_RX_HDR) || (r_state == S_RX_ADDR);
    assign fill_ready     = (r_state != S_LOOKUP);
    assign noc3_valid_out = r_noc3_valid;
    assign noc3_data_out  = r_noc3_data;

    assign w_noc2_fire = noc2_valid_in & noc2_ready_in;
    assign w_noc3_fire = r_noc3_valid & noc3_ready_out;
    assign w_fill_fire = fill_valid & fill_ready;

    assign w_idx   = r_addr[6 +: IDXW];
    assign w_tag   = r_addr[39 : 6+IDXW];
    assign w_hit   = r_vld[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_dirty = r_dirty[w_idx];
    assign w_type  = r_hdr[21:14];

    always_comb begin
        w_known     = 1'b1;
        w_ack_type  = T_INV_ACK;
        w_len2      = 1'b0;
        w_clr_vld   = 1'b0;
        w_clr_dirty = 1'b0;
        if (w_type == T_LD_FWD) begin
            w_ack_type  = T_LD_ACK;
            w_len2      = w_hit && w_dirty;
            w_clr_dirty = w_hit && w_dirty;
        end else if (w_type == T_ST_FWD) begin
            w_ack_type  = T_ST_ACK;
            w_len2      = w_hit && w_dirty;
            w_clr_vld   = w_hit;
        end else if (w_type == T_INV_FWD) begin
            w_ack_type  = T_INV_ACK;
            w_clr_vld   = w_hit;
        end else begin
            w_known     = 1'b0;
        end
    end

    // Response header echoes source ids and mshrid; only len and type are rewritten.
    assign w_resp_hdr = {r_hdr[63:30], (w_len2 ? 8'd2 : 8'd1), w_ack_type, r_hdr[13:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_RX_HDR;
            r_hdr        <= '0;
            r_addr       <= '0;
            r_len2       <= 1'b0;
            r_rdata      <= '0;
            r_noc3_valid <= 1'b0;
            r_noc3_data  <= '0;
        end else begin
            case (r_state)
                S_RX_HDR: if (w_noc2_fire) begin
                    r_hdr   <= noc2_data_in;
                    r_state <= S_RX_ADDR;
                end
                S_RX_ADDR: if (w_noc2_fire) begin
                    r_addr  <= noc2_data_in[39:0];
                    r_state <= S_LOOKUP;
                end
                S_LOOKUP: begin
                    if (!w_known) begin
                        r_state <= S_RX_HDR;
                    end else begin
                        r_len2       <= w_len2;
                        r_rdata      <= r_data[w_idx];
                        r_noc3_valid <= 1'b1;
                        r_noc3_data  <= w_resp_hdr;
                        r_state      <= S_TX_HDR;
                    end
                end
                S_TX_HDR: if (w_noc3_fire) begin
                    r_noc3_data <= {24'b0, r_addr};
                    r_state     <= S_TX_ADDR;
                end
                S_TX_ADDR: if (w_noc3_fire) begin
                    if (r_len2) begin
                        r_noc3_data <= r_rdata;
                        r_state     <= S_TX_DATA;
                    end else begin
                        r_noc3_valid <= 1'b0;
                        r_state      <= S_RX_HDR;
                    end
                end
                S_TX_DATA: if (w_noc3_fire) begin
                    r_noc3_valid <= 1'b0;
                    r_state      <= S_RX_HDR;
                end
                default: r_state <= S_RX_HDR;
            endcase
        end
    end

    // A pending fill lands after any LOOKUP update to the same index, so the fill wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld       <= '0;
            r_dirty     <= '0;
            r_fill_pend <= 1'b0;
        end else begin
            r_fill_pend <= w_fill_fire;
            if (r_state == S_LOOKUP) begin
                if (w_clr_vld)
                    r_vld[w_idx] <= 1'b0;
                if (w_clr_vld || w_clr_dirty)
                    r_dirty[w_idx] <= 1'b0;
            end
            if (r_fill_pend) begin
                r_vld[r_fill_idx]   <= 1'b1;
                r_dirty[r_fill_idx] <= r_fill_dirty;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_fill_fire) begin
            r_fill_idx   <= fill_addr[6 +: IDXW];
            r_fill_tag   <= fill_addr[39 : 6+IDXW];
            r_fill_data  <= fill_data;
            r_fill_dirty <= fill_dirty;
        end
        if (r_fill_pend) begin
            r_tag[r_fill_idx]  <= r_fill_tag;
            r_data[r_fill_idx] <= r_fill_data;
        end
    end

`ifdef L15_FWD_ERRCNT_EN
    logic [7:0] r_err_cnt;

    always_ff @(posedge clk) begin
        if (rst)
            r_err_cnt <= 8'h00;
        else if ((r_state == S_LOOKUP) && !w_known && (r_err_cnt != 8'hFF))
            r_err_cnt <= r_err_cnt + 8'd1;
    end

    assign err_cnt = r_err_cnt;
`else
    assign err_cnt = 8'h00;
`endif

endmodule
